// File: rtl/g2b_pkg.sv
// Shared types and helpers for the Gray-to-binary conversion arbiter.
package g2b_pkg;

    // Widest Gray word the shared conversion function handles.
    localparam int GRAY_MAX_W = 32;

    // Magnitude of a legal Gray-counter step between two consecutive samples.
    localparam int STEP_ONE = 1;

    // Output-slot controller states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2
    } state_t;

    // Narrower words are zero-extended by the caller. The extra leading zeros
    // leave every converted bit unchanged, so one function serves every width.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/g2b_conv_arbiter_if.sv
// Request/result bundle between the Gray sources, the arbiter and the consumer.
interface g2b_conv_arbiter_if #(
    parameter int N = 4,
    parameter int R = 4
);
    localparam int IDW = $clog2(R);

    logic [R-1:0]   req;
    logic [R*N-1:0] gray_in;
    logic [R-1:0]   gnt;
    logic           out_valid;
    logic [N-1:0]   out_bin;
    logic [IDW-1:0] out_id;
    logic           out_ready;
    logic [R-1:0]   step_err;
    logic           clr_err;

    modport master (
        output req, gray_in, out_ready, clr_err,
        input  gnt, out_valid, out_bin, out_id, step_err
    );

    modport slave (
        input  req, gray_in, out_ready, clr_err,
        output gnt, out_valid, out_bin, out_id, step_err
    );

endinterface

// File: rtl/g2b_converter.sv
// Purely combinational Gray-to-binary converter of width N.
module g2b_converter
    import g2b_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] gray,
    output logic [N-1:0] bin
);

    // Reuse the package conversion on a zero-extended copy of the word.
    always_comb begin
        bin = N'(gray2bin(GRAY_MAX_W'(gray)));
    end

endmodule

// File: rtl/g2b_conv_arbiter.sv
// Round-robin sharing of a single Gray-to-binary converter between R requesters,
// with a registered valid/ready result port and a per-requester step monitor.
module g2b_conv_arbiter
    import g2b_pkg::*;
#(
    parameter int N = 4,
    parameter int R = 4
) (
    input  logic                clk,
    input  logic                rst,
    g2b_conv_arbiter_if.slave   bus
);

    localparam int IDW = $clog2(R);
    localparam logic [N-1:0] STEP_POS = N'(STEP_ONE);
    localparam logic [N-1:0] STEP_NEG = N'(0) - STEP_POS;

    state_t         state;
    logic           out_valid_q;
    logic [N-1:0]   out_bin_q;
    logic [IDW-1:0] out_id_q;
    logic [IDW-1:0] ptr;

    logic           slot_free;
    logic           grant_any;
    logic           grant_fire;
    logic [IDW-1:0] grant_idx;
    logic [R-1:0]   grant_vec;
    logic [N-1:0]   sel_gray;
    logic [N-1:0]   sel_bin;
    int             cand;

    logic [R-1:0]   hv;
    logic [R-1:0]   step_err_q;
    logic [N-1:0]   last_bin [R];
    logic [N-1:0]   step_diff;
    logic           step_bad;

    assign slot_free  = !out_valid_q || bus.out_ready;
    assign grant_fire = slot_free && grant_any && !rst;

    // Pick the first pending request after the last winner, wrapping around.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int off = 1; off <= R; off++) begin
            cand = (int'(ptr) + off) % R;
            if (!grant_any && bus.req[cand]) begin
                grant_any = 1'b1;
                grant_idx = IDW'(cand);
            end
        end
    end

    // One-hot grant, only in a cycle where the sample is actually captured.
    always_comb begin
        grant_vec = '0;
        if (grant_fire) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    assign sel_gray = bus.gray_in[int'(grant_idx)*N +: N];

    g2b_converter #(.N(N)) u_conv (
        .gray (sel_gray),
        .bin  (sel_bin)
    );

    // Legal steps are 0, +1 and -1 modulo 2^N, which also covers the wrap points.
    always_comb begin
        step_diff = sel_bin - last_bin[grant_idx];
        step_bad  = hv[grant_idx] &&
                    !((step_diff == '0) || (step_diff == STEP_POS) || (step_diff == STEP_NEG));
    end

    // Output-slot controller: loads a converted sample on each grant and holds it under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            out_bin_q   <= '0;
            out_id_q    <= '0;
            ptr         <= IDW'(R - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (grant_fire) begin
                        state       <= ACTIVE;
                        out_valid_q <= 1'b1;
                        out_bin_q   <= sel_bin;
                        out_id_q    <= grant_idx;
                        ptr         <= grant_idx;
                    end
                end
                ACTIVE, STALL: begin
                    if (bus.out_ready) begin
                        if (grant_fire) begin
                            state       <= ACTIVE;
                            out_valid_q <= 1'b1;
                            out_bin_q   <= sel_bin;
                            out_id_q    <= grant_idx;
                            ptr         <= grant_idx;
                        end else begin
                            state       <= IDLE;
                            out_valid_q <= 1'b0;
                        end
                    end else begin
                        state <= STALL;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Step monitor: a grant's history load takes precedence over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hv         <= '0;
            step_err_q <= '0;
            for (int k = 0; k < R; k++) begin
                last_bin[k] <= '0;
            end
        end else begin
            if (bus.clr_err) begin
                hv         <= '0;
                step_err_q <= '0;
            end
            if (grant_fire) begin
                hv[grant_idx]       <= 1'b1;
                last_bin[grant_idx] <= sel_bin;
                if (step_bad && !bus.clr_err) begin
                    step_err_q[grant_idx] <= 1'b1;
                end
            end
        end
    end

    assign bus.gnt       = grant_vec;
    assign bus.out_valid = out_valid_q;
    assign bus.out_bin   = out_bin_q;
    assign bus.out_id    = out_id_q;
    assign bus.step_err  = step_err_q;

endmodule
